// File: rtl/or_nor_gate_checker.sv
// ---------------------------------------------------------------------------
// or_nor_gate_checker
//
// Self-test sequencer wrapped around a switch-level OR/NOR gate. The gate's
// inputs are driven through the four combinations 00, 01, 10, 11 (as {a,b}).
// Each vector is held for SETTLE_CYCLES cycles, then sampled for one cycle
// and checked against the OR/NOR truth table. This is repeated for PASSES
// sweeps. The block accumulates a saturating mismatch count and a sticky
// per-vector fail map, and reports overall pass/fail at the end of the run.
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before it is sampled (1..255)
//   PASSES         full 4-vector sweeps per run (1..255)
//   ERR_W          width of err_count
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      level; launches a run when seen in IDLE
//   or_in      gate's or_out
//   nor_in     gate's nor_out
//   a_drv      drives gate input a
//   b_drv      drives gate input b
//   busy       high from the cycle after launch until the run completes
//   done       one-cycle pulse at the end of a run
//   pass       1 iff the last run saw no mismatch; held until next launch
//   err_count  total mismatches, saturating at all-ones
//   fail_vec   sticky; bit k set if vector k ({a,b}=k) ever mismatched
// ---------------------------------------------------------------------------
module or_nor_gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             or_in,
    input  logic             nor_in,
    output logic             a_drv,
    output logic             b_drv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       LAST_PASS   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    state_t           state, state_nxt;
    logic [1:0]       vec, vec_nxt;
    logic [7:0]       pass_cnt, pass_cnt_nxt;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [3:0]       fail_nxt;
    logic             exp_or;
    logic             mismatch;

    // The expected response is derived from the registered drive values, not
    // from vec, so the check always matches what the gate actually sees.
    // Case inequality makes an x/z from the gate count as a mismatch; both
    // outputs wrong in one sample still count as a single error.
    always_comb begin
        exp_or   = a_drv | b_drv;
        mismatch = (or_in !== exp_or) || (nor_in !== ~exp_or);
    end

    // Next-state and next-output logic. Every registered output is computed
    // here so the outputs come straight from flops. done defaults low so it
    // is a single-cycle pulse.
    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        pass_cnt_nxt   = pass_cnt;
        settle_cnt_nxt = settle_cnt;
        a_nxt          = a_drv;
        b_nxt          = b_drv;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        pass_nxt       = pass;
        err_nxt        = err_count;
        fail_nxt       = fail_vec;

        case (state)
            IDLE: begin
                // Results of the previous run are held here until a launch
                // clears them.
                if (start) begin
                    state_nxt      = DRIVE;
                    vec_nxt        = 2'd0;
                    pass_cnt_nxt   = 8'd0;
                    settle_cnt_nxt = SETTLE_LOAD;
                    err_nxt        = '0;
                    fail_nxt       = 4'b0000;
                    pass_nxt       = 1'b0;
                    a_nxt          = 1'b0;
                    b_nxt          = 1'b0;
                    busy_nxt       = 1'b1;
                end
            end

            DRIVE: begin
                // Loaded with SETTLE_CYCLES-1 so DRIVE lasts exactly
                // SETTLE_CYCLES cycles including the one where it hits zero.
                if (settle_cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 8'd1;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_nxt = err_count + ERR_ONE;
                    end
                    fail_nxt[vec] = 1'b1;
                end

                if (vec == 2'd3 && pass_cnt == LAST_PASS) begin
                    state_nxt = DONE;
                end else begin
                    // Step to the next vector; a sweep is finished when the
                    // vector index wraps from 3 back to 0.
                    state_nxt      = DRIVE;
                    vec_nxt        = vec + 2'd1;
                    settle_cnt_nxt = SETTLE_LOAD;
                    a_nxt          = vec_nxt[1];
                    b_nxt          = vec_nxt[0];
                    if (vec == 2'd3) begin
                        pass_cnt_nxt = pass_cnt + 8'd1;
                    end
                end
            end

            DONE: begin
                // err_count already includes any increment from the final
                // sample, so pass reflects the whole run.
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                pass_nxt  = (err_count == '0);
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. Reset discards any partial run without a
    // done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            pass_cnt   <= 8'd0;
            settle_cnt <= 8'd0;
            a_drv      <= 1'b0;
            b_drv      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 4'b0000;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            pass_cnt   <= pass_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            a_drv      <= a_nxt;
            b_drv      <= b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_vec   <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_or_nor_gate_checker.sv
// ---------------------------------------------------------------------------
// tb_or_nor_gate_checker
//
// Three checker instances with different parameter sets, each wrapped around
// a behavioural OR/NOR gate whose response can be corrupted per input vector
// through flip masks (bit k flips the output for {a,b}=k). Stuck-at and
// inverted gates are expressed as particular masks.
//   inst 0: SETTLE_CYCLES=2, PASSES=4, ERR_W=8
//   inst 1: SETTLE_CYCLES=1, PASSES=1, ERR_W=8
//   inst 2: SETTLE_CYCLES=2, PASSES=4, ERR_W=2
// ---------------------------------------------------------------------------
module tb_or_nor_gate_checker;

    logic clk;
    logic rst;
    logic start_r [3];
    logic [3:0] or_flip [3];
    logic [3:0] nor_flip [3];

    logic a_w [3];
    logic b_w [3];
    logic busy_w [3];
    logic done_w [3];
    logic pass_w [3];
    logic [3:0] fv_w [3];
    logic or_w [3];
    logic nor_w [3];
    logic [7:0] err0;
    logic [7:0] err1;
    logic [1:0] err2;

    int checks;
    int failures;

    // per-cycle capture of one instance, index n = observed after edge n of the run
    logic [1:0]  cap_ab [128];
    logic        cap_busy [128];
    logic        cap_done [128];
    logic        cap_pass [128];
    logic [31:0] cap_err [128];
    logic [3:0]  cap_fv [128];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural gates with per-vector output corruption
    assign or_w[0]  =  (a_w[0] | b_w[0]) ^ or_flip[0][{a_w[0], b_w[0]}];
    assign nor_w[0] = ~(a_w[0] | b_w[0]) ^ nor_flip[0][{a_w[0], b_w[0]}];
    assign or_w[1]  =  (a_w[1] | b_w[1]) ^ or_flip[1][{a_w[1], b_w[1]}];
    assign nor_w[1] = ~(a_w[1] | b_w[1]) ^ nor_flip[1][{a_w[1], b_w[1]}];
    assign or_w[2]  =  (a_w[2] | b_w[2]) ^ or_flip[2][{a_w[2], b_w[2]}];
    assign nor_w[2] = ~(a_w[2] | b_w[2]) ^ nor_flip[2][{a_w[2], b_w[2]}];

    or_nor_gate_checker #(.SETTLE_CYCLES(2), .PASSES(4), .ERR_W(8)) u_chk0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .or_in(or_w[0]), .nor_in(nor_w[0]),
        .a_drv(a_w[0]), .b_drv(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err0), .fail_vec(fv_w[0])
    );

    or_nor_gate_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(8)) u_chk1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .or_in(or_w[1]), .nor_in(nor_w[1]),
        .a_drv(a_w[1]), .b_drv(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err1), .fail_vec(fv_w[1])
    );

    or_nor_gate_checker #(.SETTLE_CYCLES(2), .PASSES(4), .ERR_W(2)) u_chk2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .or_in(or_w[2]), .nor_in(nor_w[2]),
        .a_drv(a_w[2]), .b_drv(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err2), .fail_vec(fv_w[2])
    );

    function automatic int settle_of(input int id);
        return (id == 1) ? 1 : 2;
    endfunction

    function automatic int passes_of(input int id);
        return (id == 1) ? 1 : 4;
    endfunction

    function automatic int err_max_of(input int id);
        return (id == 2) ? 3 : 255;
    endfunction

    // cycles from the launch edge to the edge that raises done
    function automatic int run_len(input int id);
        return 1 + passes_of(id) * 4 * (settle_of(id) + 1);
    endfunction

    // reference: every pass each corrupted vector costs one error, saturating
    function automatic logic [31:0] exp_errors(input int id, input logic [3:0] bad);
        int e;
        e = passes_of(id) * $countones(bad);
        if (e > err_max_of(id)) e = err_max_of(id);
        return 32'(e);
    endfunction

    // reference schedule: vector k is on the gate for SETTLE+1 cycles in
    // sweep order 00,01,10,11; the DONE cycle still shows 11; busy high and
    // done low throughout. Returns the number of captured cycles that deviate.
    function automatic int count_seq_dev(input int id);
        int s1, len, dev;
        logic [1:0] exp_ab;
        s1  = settle_of(id) + 1;
        len = run_len(id);
        dev = 0;
        for (int n = 0; n < len; n++) begin
            if (n < len - 1) exp_ab = 2'((n / s1) % 4);
            else exp_ab = 2'd3;
            if (cap_ab[n] !== exp_ab || cap_busy[n] !== 1'b1 || cap_done[n] !== 1'b0)
                dev++;
        end
        return dev;
    endfunction

    task automatic observe(input int id, output logic [1:0] ab, output logic bz,
                           output logic dn, output logic ps, output logic [31:0] ec,
                           output logic [3:0] fv);
        ab = {a_w[id], b_w[id]};
        bz = busy_w[id];
        dn = done_w[id];
        ps = pass_w[id];
        fv = fv_w[id];
        case (id)
            0: ec = {24'd0, err0};
            1: ec = {24'd0, err1};
            default: ec = {30'd0, err2};
        endcase
    endtask

    // Launches a run on one instance and captures its outputs every cycle.
    // mode 0: one-cycle start pulse; 1: start held high; 2: random start
    // while n < rand_until, then low.
    task automatic run_sweep(input int id, input logic [3:0] om, input logic [3:0] nm,
                             input int mode, input int rand_until, input int cycles);
        or_flip[id]  = om;
        nor_flip[id] = nm;
        @(negedge clk);
        start_r[id] = 1'b1;
        @(negedge clk);
        for (int n = 0; n < cycles; n++) begin
            observe(id, cap_ab[n], cap_busy[n], cap_done[n], cap_pass[n], cap_err[n], cap_fv[n]);
            case (mode)
                0: start_r[id] = 1'b0;
                1: start_r[id] = (n < cycles - 1);
                default: start_r[id] = (n < rand_until) ? 1'($urandom_range(0, 1)) : 1'b0;
            endcase
            if (n < cycles - 1) @(negedge clk);
        end
        start_r[id] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [1:0] ab; logic bz, dn, ps; logic [31:0] ec; logic [3:0] fv;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            observe(id, ab, bz, dn, ps, ec, fv);
            checks++;
            if (ab !== 2'b00 || bz !== 1'b0 || dn !== 1'b0 || ps !== 1'b0 || ec !== 32'd0 || fv !== 4'd0) begin
                failures++;
                $display("[TB] FAIL reset_state inst%0d: ab=%b busy=%b done=%b pass=%b err=%0d fv=%b, required all zero",
                         id, ab, bz, dn, ps, ec, fv);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_run;
        int len, dev;
        len = run_len(0);
        run_sweep(0, 4'b0000, 4'b0000, 0, 0, len + 3);
        dev = count_seq_dev(0);
        checks++;
        if (dev !== 0) begin
            failures++;
            $display("[TB] FAIL clean_sequence: %0d deviating cycles, required 0", dev);
        end
        checks++;
        if (cap_done[len] !== 1'b1 || cap_busy[len] !== 1'b0 || cap_ab[len] !== 2'b00) begin
            failures++;
            $display("[TB] FAIL clean_done_cycle: done=%b busy=%b ab=%b at cycle %0d, required 1 0 00",
                     cap_done[len], cap_busy[len], cap_ab[len], len);
        end
        checks++;
        if (cap_pass[len] !== 1'b1 || cap_err[len] !== 32'd0 || cap_fv[len] !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL clean_result: pass=%b err=%0d fv=%b, required 1 0 0000",
                     cap_pass[len], cap_err[len], cap_fv[len]);
        end
        checks++;
        if (cap_done[len + 1] !== 1'b0 || cap_busy[len + 1] !== 1'b0 || cap_pass[len + 2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_idle_hold: done=%b busy=%b pass=%b, required 0 0 1",
                     cap_done[len + 1], cap_busy[len + 1], cap_pass[len + 2]);
        end
    endtask

    task automatic test_nor_stuck_low;
        int len;
        len = run_len(0);
        run_sweep(0, 4'b0000, 4'b0001, 0, 0, len + 3);
        checks++;
        if (cap_done[len] !== 1'b1 || cap_err[len] !== 32'd4 || cap_fv[len] !== 4'b0001 || cap_pass[len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nor_stuck_low: done=%b err=%0d fv=%b pass=%b, required 1 4 0001 0",
                     cap_done[len], cap_err[len], cap_fv[len], cap_pass[len]);
        end
        checks++;
        if (cap_err[len + 2] !== 32'd4 || cap_fv[len + 2] !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL nor_stuck_hold: err=%0d fv=%b, required 4 0001", cap_err[len + 2], cap_fv[len + 2]);
        end
    endtask

    task automatic test_or_stuck;
        int len, dev;
        len = run_len(1);
        run_sweep(1, 4'b0001, 4'b0000, 0, 0, len + 3);
        dev = count_seq_dev(1);
        checks++;
        if (dev !== 0) begin
            failures++;
            $display("[TB] FAIL short_sequence: %0d deviating cycles, required 0", dev);
        end
        checks++;
        if (cap_done[len] !== 1'b1 || cap_err[len] !== 32'd1 || cap_fv[len] !== 4'b0001 || cap_pass[len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL or_stuck_high: done=%b err=%0d fv=%b pass=%b, required 1 1 0001 0",
                     cap_done[len], cap_err[len], cap_fv[len], cap_pass[len]);
        end
        run_sweep(1, 4'b1110, 4'b0000, 0, 0, len + 3);
        checks++;
        if (cap_done[len] !== 1'b1 || cap_err[len] !== 32'd3 || cap_fv[len] !== 4'b1110 || cap_pass[len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL or_stuck_low: done=%b err=%0d fv=%b pass=%b, required 1 3 1110 0",
                     cap_done[len], cap_err[len], cap_fv[len], cap_pass[len]);
        end
    endtask

    task automatic test_saturation;
        int len;
        len = run_len(2);
        run_sweep(2, 4'b1111, 4'b1111, 0, 0, len + 3);
        checks++;
        if (cap_done[len] !== 1'b1 || cap_err[len] !== 32'd3 || cap_fv[len] !== 4'b1111 || cap_pass[len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL saturation: done=%b err=%0d fv=%b pass=%b, required 1 3 1111 0",
                     cap_done[len], cap_err[len], cap_fv[len], cap_pass[len]);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [1:0] ab; logic bz, dn, ps; logic [31:0] ec; logic [3:0] fv;
        int done_seen, len;
        or_flip[0]  = 4'b0001;
        nor_flip[0] = 4'b0000;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        observe(0, ab, bz, dn, ps, ec, fv);
        checks++;
        if (ab !== 2'b00 || bz !== 1'b0 || dn !== 1'b0 || ec !== 32'd0 || fv !== 4'd0 || ps !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_run_reset: ab=%b busy=%b done=%b err=%0d fv=%b pass=%b, required all zero",
                     ab, bz, dn, ec, fv, ps);
        end
        done_seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("[TB] FAIL reset_no_done: %0d cycles with done/busy activity, required 0", done_seen);
        end
        len = run_len(0);
        run_sweep(0, 4'b0000, 4'b0000, 0, 0, len + 3);
        checks++;
        if (count_seq_dev(0) !== 0 || cap_done[len] !== 1'b1 || cap_pass[len] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_run: dev=%0d done=%b pass=%b, required 0 1 1",
                     count_seq_dev(0), cap_done[len], cap_pass[len]);
        end
    endtask

    task automatic test_start_held;
        int len;
        len = run_len(1);
        run_sweep(1, 4'b0000, 4'b0000, 1, 0, 2 * len + 2);
        checks++;
        if (count_seq_dev(1) !== 0 || cap_done[len] !== 1'b1 || cap_busy[len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_first_run: dev=%0d done=%b busy=%b at cycle %0d, required 0 1 0",
                     count_seq_dev(1), cap_done[len], cap_busy[len], len);
        end
        checks++;
        if (cap_busy[len + 1] !== 1'b1 || cap_done[len + 1] !== 1'b0 || cap_ab[len + 1] !== 2'b00) begin
            failures++;
            $display("[TB] FAIL held_relaunch: busy=%b done=%b ab=%b, required 1 0 00",
                     cap_busy[len + 1], cap_done[len + 1], cap_ab[len + 1]);
        end
        checks++;
        if (cap_done[2 * len + 1] !== 1'b1 || cap_done[2 * len] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_second_done: done@%0d=%b done@%0d=%b, required 0 1",
                     2 * len, cap_done[2 * len], 2 * len + 1, cap_done[2 * len + 1]);
        end
    endtask

    task automatic test_start_ignored;
        int len;
        len = run_len(0);
        run_sweep(0, 4'b0100, 4'b0000, 2, len, len + 3);
        checks++;
        if (count_seq_dev(0) !== 0 || cap_done[len] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored: dev=%0d done=%b, required 0 1", count_seq_dev(0), cap_done[len]);
        end
        checks++;
        if (cap_err[len] !== 32'd4 || cap_fv[len] !== 4'b0100 || cap_busy[len + 1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_start_result: err=%0d fv=%b busy=%b, required 4 0100 0",
                     cap_err[len], cap_fv[len], cap_busy[len + 1]);
        end
    endtask

    task automatic test_random;
        int id, len;
        logic [3:0] om, nm;
        for (int it = 0; it < 8; it++) begin
            id  = $urandom_range(0, 2);
            om  = 4'($urandom);
            nm  = 4'($urandom);
            len = run_len(id);
            run_sweep(id, om, nm, 2 * (it % 2), len, len + 3);
            checks++;
            if (count_seq_dev(id) !== 0 || cap_done[len] !== 1'b1 || cap_err[len] !== exp_errors(id, om | nm) ||
                cap_fv[len] !== (om | nm) || cap_pass[len] !== ((om | nm) == 4'd0)) begin
                failures++;
                $display("[TB] FAIL random_run%0d inst%0d om=%b nm=%b: dev=%0d done=%b err=%0d fv=%b pass=%b, required 0 1 %0d %b %b",
                         it, id, om, nm, count_seq_dev(id), cap_done[len], cap_err[len], cap_fv[len],
                         cap_pass[len], exp_errors(id, om | nm), om | nm, (om | nm) == 4'd0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_r[i]  = 1'b0;
            or_flip[i]  = 4'b0000;
            nor_flip[i] = 4'b0000;
        end
        test_reset();
        test_clean_run();
        test_nor_stuck_low();
        test_or_stuck();
        test_saturation();
        test_reset_mid_run();
        test_start_held();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_nor_gate_checker.md
Name: or_nor_gate_checker

Overview:
- Self-test sequencer placed around the switch-level OR/NOR gate.
- Upstream, it drives the gate's a/b inputs through all four input combinations. Downstream, it samples or_out/nor_out after a settle delay and checks them against the truth table.
- It reports pass/fail, a saturating error count and a per-vector sticky fail map, so gate-level CMOS cells can be checked in simulation by one clocked block.

Parameters:
- SETTLE_CYCLES, 2, cycles a vector is held before sampling; legal range 1..255.
- PASSES, 4, number of full 4-vector sweeps per run; legal range 1..255.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; launches a run.
- or_in  input  1  gate's or_out.
- nor_in  input  1  gate's nor_out.
- a_drv  output  1  drives gate input a.
- b_drv  output  1  drives gate input b.
- busy  output  1  high from the cycle after start until DONE.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  valid after done: 1 iff err_count==0; held until the next start.
- err_count  output  ERR_W  total mismatches; saturates at all-ones.
- fail_vec  output  4  sticky; bit k set if vector k ({a,b}=k) ever mismatched.

Behaviour:
- Reset values: state IDLE; a_drv=0, b_drv=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - On that transition: vector index v=0, pass counter p=0, settle counter s=SETTLE_CYCLES-1, err_count=0, fail_vec=0, pass=0.
  - Registered {a_drv,b_drv}=v; busy=1 from the next cycle.
- DRIVE: hold {a_drv,b_drv}=v. If s==0 → SAMPLE; else s decrements. Occupancy is exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - Expected or = a_drv|b_drv; expected nor = ~(a_drv|b_drv).
  - Either input differing (case-inequality: x/z counts as mismatch) → err_count+1 unless already all-ones, and fail_vec[v] set.
  - Both wrong in one SAMPLE counts as 1 error.
  - If v==3 and p==PASSES-1 → DONE.
  - Else v=v+1 mod 4, p increments on the 3→0 wrap, s reloaded, → DRIVE. The new vector appears on a_drv/b_drv the cycle after SAMPLE.
- Vector order per pass: 00, 01, 10, 11.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0 including any increment from the final SAMPLE), a_drv=b_drv=0 → IDLE.
- Run length from start sampled to done high: 1 + PASSES*4*(SETTLE_CYCLES+1) cycles.
- start while busy or in DONE is ignored. start held high in IDLE after DONE relaunches on the next cycle.
- err_count, fail_vec and pass hold their values in IDLE until the next launch.
- rst asserted at any clock edge, including mid-run, forces all reset values that cycle. No done pulse is generated and partial results are discarded.
- Counters v (2 bits), p (8 bits) and s (8 bits) wrap only as described. Parameters outside their legal range are unsupported.

Test Plan:
- Gate instance connected correctly, defaults, start pulsed 1 cycle → done at cycle 49 after start sampled; pass=1, err_count=0, fail_vec=0; a_drv/b_drv sequence 00,01,10,11 repeated 4×, each held 3 cycles.
- nor_in forced to 0 for whole run, defaults → only vector 00 wrong; err_count=4, fail_vec=4'b0001, pass=0.
- or_in stuck at 1, PASSES=1 → error on vector 00 only; err_count=1, fail_vec=0001. Then or_in stuck at 0 → errors on 01/10/11; err_count=3, fail_vec=1110.
- ERR_W=2, or_in and nor_in both inverted, PASSES=4 → 16 mismatches; err_count saturates at 3, fail_vec=1111, pass=0.
- rst asserted mid-run (cycle 20) → next cycle busy=0, done never pulses, err_count=0, a_drv=b_drv=0; a subsequent start runs a full 49-cycle run.
- start held high continuously, SETTLE_CYCLES=1, PASSES=1 → done after 9 cycles, then IDLE one cycle, relaunch; start pulses during busy have no effect.
